fifo_wr_arb: RTL

Round-robin write-port arbiter that shares the 8-bit, 16-deep `fifo` write interface among four producers. It sits directly in front of the FIFO and grants one owner at a time for a bounded burst. It steers that owner's data onto the FIFO write port, stalls on `full`, and rotates priority after each burst so that no producer starves.

---
 rtl/fifo_wr_arb_if.sv | 27 ++
 rtl/fifo_wr_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the FIFO write port.
interface fifo_wr_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic               fifo_full;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic [OW-1:0]      owner;
   logic               busy;
   logic               fifo_we;
   logic [DW-1:0]      fifo_data;

   modport master (
      output req, req_data, fifo_full,
      input  gnt, ack, owner, busy, fifo_we, fifo_data
   );

   modport slave (
      input  req, req_data, fifo_full,
      output gnt, ack, owner, busy, fifo_we, fifo_data
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// granting bounded bursts and rotating priority away from the outgoing owner.
module fifo_wr_arb #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input logic          clk,
   input logic          rst,
   fifo_wr_arb_if.slave bus
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] ack_c;
   logic            we_c;
   logic [DW-1:0]   data_c;
   logic            own_req;
   logic            burst_end;
   logic [OW:0]     pick;
   logic [OW-1:0]   ptr_nxt;

   // Returns {found, index} of the first set request at or after ptr, wrapping.
   function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
      logic          found;
      logic [OW-1:0] win;
      int unsigned   idx;
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (!found && r[OW'(idx)]) begin
            found = 1'b1;
            win   = OW'(idx);
         end
      end
      return {found, win};
   endfunction

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      ack_c      = '0;
      we_c       = 1'b0;
      data_c     = '0;
      own_req    = 1'b0;
      burst_end  = 1'b0;
      pick       = '0;
      ptr_nxt    = '0;

      case (state_q)
         IDLE: begin
            pick = rr_pick(bus.req, rr_ptr_q);
            if (pick[OW]) begin
               state_d    = BUSY;
               owner_d    = pick[OW-1:0];
               gnt_d      = NREQ'(1) << pick[OW-1:0];
               beat_cnt_d = '0;
            end
         end
         BUSY: begin
            own_req = bus.req[owner_q];
            if (own_req && !bus.fifo_full) begin
               ack_c[owner_q] = 1'b1;
               we_c           = 1'b1;
               beat_cnt_d     = beat_cnt_q + BW'(1);
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (owner_q == OW'(i)) data_c = bus.req_data[i*DW +: DW];
               end
            end
            burst_end = (we_c && (beat_cnt_q == BW'(MAX_BURST - 1))) || !own_req;
            // Handoff re-arbitrates this cycle so the outgoing owner ranks last.
            if (burst_end) begin
               ptr_nxt    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
               rr_ptr_d   = ptr_nxt;
               pick       = rr_pick(bus.req, ptr_nxt);
               beat_cnt_d = '0;
               if (pick[OW]) begin
                  owner_d = pick[OW-1:0];
                  gnt_d   = NREQ'(1) << pick[OW-1:0];
               end else begin
                  state_d = IDLE;
                  owner_d = '0;
                  gnt_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         ack_c  = '0;
         we_c   = 1'b0;
         data_c = '0;
      end

      busy_d = (state_d == BUSY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = busy_q;
   assign bus.ack       = ack_c;
   assign bus.fifo_we   = we_c;
   assign bus.fifo_data = data_c;
endmodule
